game_timer_ctrl: RTL
====================

GAME_TIMER_CTRL -- requirements
Module: game_timer_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000: clock cycles per counted second; legal range >= 2.
REQ-002 SHALL have parameter SEC_W, default 8: width of all second-valued ports.
REQ-003 SHALL have the port: CLK  in  1  single clock; all logic on rising edge.
REQ-004 SHALL have the port: RESET  in  1  synchronous, active-high reset.
REQ-005 SHALL have the port: start  in  1  one-cycle request to begin a round.
REQ-006 SHALL have the port: pause  in  1  one-cycle request to freeze the round.
REQ-007 SHALL have the port: resume  in  1  one-cycle request to continue a paused round.
REQ-008 SHALL have the port: abort  in  1  one-cycle request to end the round with no expiry.
REQ-009 SHALL have the port: limit  in  SEC_W  round length in seconds; sampled only on an accepted start.
REQ-010 SHALL have the port: sec_elapsed  out  SEC_W  whole seconds elapsed in the current or last round.
REQ-011 SHALL have the port: sec_left  out  SEC_W  latched limit minus sec_elapsed.
REQ-012 SHALL have the port: running  out  1  high in RUN.
REQ-013 SHALL have the port: paused  out  1  high in PAUSE.
REQ-014 SHALL have the port: expired  out  1  one-cycle pulse when the round reaches its limit.
REQ-015 SHALL have the port: state  out  3  current FSM state encoding.

Function
REQ-016 SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-017 In IDLE or DONE, start SHALL latch limit, clear sec_elapsed and the prescaler, and enter RUN on the next cycle.
REQ-018 On an accepted start with limit==0, the block SHALL go directly to DONE, pulse expired once, and hold sec_elapsed=0.
REQ-019 In RUN, the prescaler SHALL increment once per cycle; when it reaches CLK_HZ-1, it SHALL wrap to 0 and issue a tick.
REQ-020 Each tick SHALL increment sec_elapsed by 1, registered with no additional latency.
REQ-021 When a tick makes sec_elapsed equal the latched limit, the FSM SHALL enter DONE and expired SHALL pulse in that same cycle.
REQ-022 sec_elapsed SHALL never exceed the latched limit and SHALL never wrap.
REQ-023 In RUN, pause SHALL enter PAUSE; the prescaler and sec_elapsed SHALL hold their values, so the fractional second is preserved.
REQ-024 In PAUSE, resume SHALL return to RUN, and counting SHALL continue from the held prescaler value.
REQ-025 abort in RUN or PAUSE SHALL enter IDLE, hold sec_elapsed, clear the prescaler, and produce no expired pulse.
REQ-026 Simultaneous requests SHALL be resolved with the priority abort > start > pause > resume.
REQ-027 start SHALL be ignored in RUN and PAUSE.
REQ-028 pause SHALL be ignored outside RUN, and resume SHALL be ignored outside PAUSE.
REQ-029 If a tick reaching the limit coincides with pause, the expiry SHALL win: the FSM enters DONE and expired pulses.
REQ-030 If a tick coincides with abort, abort SHALL win: no increment and no expired pulse.
REQ-031 DONE SHALL hold sec_elapsed=limit and sec_left=0 until the next start.
REQ-032 sec_left SHALL be computed combinationally as limit_q - sec_elapsed and SHALL never underflow.

Reset
REQ-033 RESET SHALL be synchronous and active-high.
REQ-034 While RESET is high, the block SHALL drive state=IDLE, with sec_elapsed, sec_left, prescaler and latched limit all 0.
REQ-035 While RESET is high, running, paused and expired SHALL all be 0.
REQ-036 RESET SHALL take priority over every request, including a reset asserted mid-round; no expired pulse SHALL be generated.

Structure
REQ-037 A shared package game_timer_pkg SHALL hold the state enum (IDLE=0, RUN=1, PAUSE=2, DONE=3) and the default CLK_HZ constant.
REQ-038 The prescaler SHALL be one sub-module, sec_prescaler, with inputs CLK, RESET, clr and en and a one-cycle output tick.
REQ-039 The FSM, second counter and priority logic SHALL live in the top-level module.

Verification (benches use CLK_HZ=4, SEC_W=8)
REQ-040 Normal run: start with limit=3 -> running after 1 cycle; sec_elapsed steps 1,2,3 at 4-cycle intervals; expired pulses once at 3; state=DONE; sec_left=0.
REQ-041 Pause preserving fraction: start limit=5, pause after 6 RUN cycles, hold 10 cycles, then resume -> sec_elapsed=1 throughout PAUSE; the next tick arrives 2 cycles after resume.
REQ-042 Zero limit: start with limit=0 -> DONE next cycle, expired pulses once, running never asserts.
REQ-043 Simultaneous events: assert pause on the same cycle as the final tick (limit=2) -> DONE and expired pulse; assert abort together with start in RUN -> IDLE, no expired pulse.
REQ-044 Reset mid-round: RESET at sec_elapsed=2 of limit=4 -> next cycle all outputs 0, state=IDLE; no expired pulse for 20 cycles afterwards.
REQ-045 Ignored requests: start in PAUSE and resume in RUN -> no change to state, sec_elapsed or latched limit.

Source files
------------

// File: rtl/game_timer_pkg.sv
// Shared definitions for the game round timer: FSM state encoding and the
// default clock rate used to count whole seconds.
package game_timer_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        DONE  = 3'd3
    } state_e;

endpackage

// File: rtl/sec_prescaler.sv
// Divides the clock down to a one-cycle tick per counted second. The count is
// held while disabled so a paused round keeps its fractional second.
module sec_prescaler
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_HZ > 32'd2) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_HZ - 32'd1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // clr dominates en so a restart or abort always begins a fresh second
    assign tick = en && !clr && (cnt_q == LAST);

    // Next count: clear, wrap on the last cycle of a second, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_timer_ctrl.sv
// Round timer: IDLE/RUN/PAUSE/DONE control with a saturating seconds counter,
// request priority abort > start > pause > resume, and a one-cycle expiry pulse.
module game_timer_ctrl
    import game_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
    parameter int unsigned SEC_W  = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic             pause,
    input  logic             resume,
    input  logic             abort,
    input  logic [SEC_W-1:0] limit,
    output logic [SEC_W-1:0] sec_elapsed,
    output logic [SEC_W-1:0] sec_left,
    output logic             running,
    output logic             paused,
    output logic             expired,
    output logic [2:0]       state
);

    state_e           state_q;
    state_e           state_d;
    logic [SEC_W-1:0] sec_q;
    logic [SEC_W-1:0] sec_d;
    logic [SEC_W-1:0] limit_q;
    logic [SEC_W-1:0] limit_d;
    logic             expired_q;
    logic             expired_d;

    logic             in_round;
    logic             start_ok;
    logic             ps_clr;
    logic             ps_en;
    logic             tick;
    logic [SEC_W-1:0] sec_inc;

    assign in_round = (state_q == RUN) || (state_q == PAUSE);
    assign start_ok = start && !abort && !in_round;
    assign ps_clr   = start_ok || (abort && in_round);
    // Abort suppresses the tick so a coincident second is never counted
    assign ps_en    = (state_q == RUN) && !abort;
    // sec_q < limit_q whenever RUN ticks, so the increment cannot wrap
    assign sec_inc  = sec_q + SEC_W'(1);

    sec_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .clr   (ps_clr),
        .en    (ps_en),
        .tick  (tick)
    );

    // Next-state, seconds counter and expiry decision
    always_comb begin
        state_d   = state_q;
        sec_d     = sec_q;
        limit_d   = limit_q;
        expired_d = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start_ok) begin
                    limit_d = limit;
                    sec_d   = {SEC_W{1'b0}};
                    if (limit == {SEC_W{1'b0}}) begin
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end else begin
                        state_d = RUN;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (tick) begin
                    sec_d = sec_inc;
                    // Reaching the limit outranks a coincident pause
                    if (sec_inc == limit_q) begin
                        state_d   = DONE;
                        expired_d = 1'b1;
                    end else if (pause) begin
                        state_d = PAUSE;
                    end else begin
                        state_d = RUN;
                    end
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (resume) begin
                    state_d = RUN;
                end else begin
                    state_d = PAUSE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, latched limit and expiry pulse registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            sec_q     <= {SEC_W{1'b0}};
            limit_q   <= {SEC_W{1'b0}};
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            limit_q   <= limit_d;
            expired_q <= expired_d;
        end
    end

    assign sec_elapsed = sec_q;
    assign sec_left    = limit_q - sec_q;
    assign running     = (state_q == RUN);
    assign paused      = (state_q == PAUSE);
    assign expired     = expired_q;
    assign state       = state_q;

endmodule
